pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
// - Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.
// - Reports the period in clk cycles and the duty in integer percent (0..100).
// - Uses the same 12-bit period / 7-bit duty format that the generator accepts.
// - Sits on a pin/loopback input; a sel/rd_data register port lets firmware or a bench read results.
// PARAMETERS
// - WIDTH        12  counter and period width in bits
// - SYNC_STAGES  2   input synchronizer flops (>=2)
// PORTS
// - clk      in   1      system clock
// - rst      in   1      asynchronous, active-high reset
// - pwm_in   in   1      asynchronous PWM input
// - sel      in   1      1: rd_data = period_q; 0: rd_data = {5'b0, duty_q}
// - ovr_clr  in   1      synchronous clear of overrun
// - rd_data  out  WIDTH  combinational mux of the result registers
// - valid    out  1      1-cycle pulse when period_q/duty_q update
// - busy     out  1      high while state==DIVIDE
// - overrun  out  1      sticky: a sample was dropped
// BEHAVIOUR
// - Reset: period_q=0, duty_q=0, valid=0, overrun=0, counters=0, state=IDLE.
// - Input: SYNC_STAGES synchronizer, then a registered edge detector.
//   rise = sync & ~prev. Pin-to-rise latency is SYNC_STAGES+1 cycles.
// - States: IDLE, MEASURE, DIVIDE.
// - IDLE: wait for rise. On rise, clear per_cnt/hi_cnt and go to MEASURE.
// - MEASURE, each cycle: per_cnt+=1; hi_cnt+=1 when sync=1. Both saturate at 2^WIDTH-1.
// - Rise in MEASURE at cycle E:
//   - per_cnt+1 and hi_cnt (+1 if high) are latched as samples; counters restart.
//   - Go to DIVIDE. Counting of the next period continues in parallel.
// - Period definition: per = clk cycles from one rise to the next.
//   Example: generator period P -> per=P.
// - DIVIDE: 7-iteration restoring divide, quotient = floor(hi*100/per), 7 bits.
//   - Numerator is WIDTH+7 bits wide; quotient is always <=100.
//   - At E+8: period_q<=per, duty_q<=quotient, valid=1 for one cycle; return to MEASURE.
// - Rise during DIVIDE: that sample is dropped and overrun<=1. Counters still restart.
//   The minimum measurable period is therefore 8 cycles.
// - Timeout: per_cnt reaches 2^WIDTH-1 with no rise:
//   - period_q<=0; duty_q<=100 if sync=1, else 0; valid pulses once.
//   - State goes to IDLE.
// - Simultaneous ovr_clr and a new overrun event: set wins.
// - Reset asserted mid-measure or mid-divide aborts immediately to the reset values.
//   No valid is issued.
// - rd_data changes only at valid (or reset); it is never torn mid-divide.
// CONFIGURATION
// - Macro PWM_CAPTURE_DEGLITCH_EN.
// - Defined: a 3-sample majority filter follows the synchronizer.
//   - Pulses shorter than 2 cycles are rejected.
//   - Pin-to-rise latency becomes SYNC_STAGES+3.
//   - Period measurement is unchanged for clean inputs.
// - Undefined: the synchronizer output feeds the edge detector directly. No filter logic.
// TESTING
// - Generator period=200, duty=30 looped back:
//   2nd result period_q=200, duty_q=30, valid 8 cycles after rise detect.
// - per=7 high=3 (glitch-free):
//   - 1st rise starts MEASURE; 2nd rise latches a sample and enters DIVIDE.
//   - 3rd rise arrives during DIVIDE -> overrun=1, sample dropped.
//   - ovr_clr -> overrun=0.
// - pwm_in held 1 after one rise, no further edge:
//   after 4095 cycles period_q=0, duty_q=100, single valid, state IDLE.
// - per=100 high=33: duty_q=33. per=3000 high=1: duty_q=0 (truncation).
//   sel=1 -> rd_data=3000; sel=0 -> rd_data=0.
// - Assert rst during DIVIDE:
//   - All outputs are 0 next cycle and no valid occurs.
//   - After release, the first result needs two new rises.
// - With PWM_CAPTURE_DEGLITCH_EN: a 1-cycle spike inside a high phase is ignored.
//   Without it, the same spike causes overrun or a shortened period.

Source files
------------

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_capture                                                  |
// | Description : Measures an incoming PWM waveform. Reports the period in     |
// |               clk cycles and the duty in integer percent (0..100), using   |
// |               the same WIDTH-bit period / 7-bit duty format that the PWM   |
// |               generator accepts.                                           |
// | Option      : PWM_CAPTURE_DEGLITCH_EN - when defined, a 3-sample majority  |
// |               filter follows the synchronizer and rejects pulses shorter   |
// |               than 2 cycles (adds 2 cycles of pin-to-edge latency).        |
// | Ports       : clk      - system clock                                      |
// |               rst      - asynchronous active-high reset                    |
// |               pwm_in   - asynchronous PWM input                            |
// |               sel      - 1: rd_data = period, 0: rd_data = duty            |
// |               ovr_clr  - synchronous clear of the overrun flag             |
// |               rd_data  - result register read mux                          |
// |               valid    - 1-cycle pulse when a new result is stored         |
// |               busy     - high while the duty divider runs                  |
// |               overrun  - sticky, a sample was dropped                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_capture #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             sel,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  // Numerator hi*100 needs 7 extra bits (100 < 2^7).
  localparam int NUM_W = WIDTH + 7;

  localparam logic [WIDTH-1:0] c_cnt_max   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_cnt_one   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] c_hundred   = NUM_W'(100);
  localparam logic [6:0]       c_duty_full = 7'd100;
  localparam logic [2:0]       c_div_last  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DIVIDE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_bit;
  logic                   sig;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
  // Majority of the current and two previous synchronized samples: a single
  // cycle that disagrees with both neighbours never reaches the edge detector.
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  always_comb begin
    hist_d = {hist_q[0], sync_bit};
    filt_d = (sync_bit & hist_q[0]) | (sync_bit & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign sig = filt_q;
`else
  assign sig = sync_bit;
`endif

  // --------------------------------------------------------------------------
  // Registered edge detector. prev_q is the input level aligned with rise_q,
  // so it is the level used for high-time counting.
  // --------------------------------------------------------------------------
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic level;

  assign prev_d = sig;
  assign rise_d = sig & ~prev_q;
  assign level  = prev_q;

  // --------------------------------------------------------------------------
  // Measurement / divide datapath
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] div_per_q, div_per_d;
  logic [NUM_W-1:0] div_rem_q, div_rem_d;
  logic [NUM_W-1:0] div_dvs_q, div_dvs_d;
  logic [6:0]       div_quo_q, div_quo_d;
  logic [2:0]       div_it_q, div_it_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [6:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sample_per;
  logic [WIDTH-1:0] sample_hi;
  logic             div_ge;
  logic             ovr_set;

  // The rise cycle itself belongs to the period that just ended, hence +1
  // (and +level for the high count); both saturate like the counters.
  assign sample_per = (per_cnt_q == c_cnt_max) ? c_cnt_max : per_cnt_q + c_cnt_one;
  assign sample_hi  = (hi_cnt_q == c_cnt_max) ? c_cnt_max
                                               : hi_cnt_q + {{(WIDTH-1){1'b0}}, level};

  // Restoring divide with a pre-shifted divisor: the divisor starts at per<<6
  // and shifts right each step, producing one quotient bit MSB first. Since
  // hi <= per, hi*100 < per*128 and 7 quotient bits always suffice.
  assign div_ge = (div_rem_q >= div_dvs_q);

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    div_per_d = div_per_q;
    div_rem_d = div_rem_q;
    div_dvs_d = div_dvs_q;
    div_quo_d = div_quo_q;
    div_it_d  = div_it_q;
    period_d  = period_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    ovr_set   = 1'b0;

    // Counters run in MEASURE and keep running through DIVIDE so the next
    // period is measured without a gap.
    if (state_q != S_IDLE) begin
      if (per_cnt_q != c_cnt_max) per_cnt_d = per_cnt_q + c_cnt_one;
      if (level && (hi_cnt_q != c_cnt_max)) hi_cnt_d = hi_cnt_q + c_cnt_one;
    end

    case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = S_MEASURE;
        end
      end

      S_MEASURE: begin
        if (rise_q) begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          div_per_d = sample_per;
          div_rem_d = NUM_W'(sample_hi) * c_hundred;
          div_dvs_d = {1'b0, sample_per, 6'b000000};
          div_quo_d = 7'd0;
          div_it_d  = 3'd0;
          state_d   = S_DIVIDE;
        end else if (per_cnt_q == c_cnt_max) begin
          // No edge for a full counter range: report a stuck level.
          period_d = '0;
          duty_d   = level ? c_duty_full : 7'd0;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_DIVIDE: begin
        if (rise_q) begin
          // The divider is still busy with the previous sample; this one is
          // lost, but the next period still starts counting from this edge.
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          ovr_set   = 1'b1;
        end
        if (div_ge) div_rem_d = div_rem_q - div_dvs_q;
        div_dvs_d = div_dvs_q >> 1;
        div_quo_d = {div_quo_q[5:0], div_ge};
        div_it_d  = div_it_q + 3'd1;
        if (div_it_q == c_div_last) begin
          period_d = div_per_q;
          duty_d   = {div_quo_q[5:0], div_ge};
          valid_d  = 1'b1;
          state_d  = S_MEASURE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new overrun event takes priority over a simultaneous clear.
    if (ovr_set)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      rise_q    <= 1'b0;
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      div_per_q <= '0;
      div_rem_q <= '0;
      div_dvs_q <= '0;
      div_quo_q <= 7'd0;
      div_it_q  <= 3'd0;
      period_q  <= '0;
      duty_q    <= 7'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      div_per_q <= div_per_d;
      div_rem_q <= div_rem_d;
      div_dvs_q <= div_dvs_d;
      div_quo_q <= div_quo_d;
      div_it_q  <= div_it_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Result registers only change together with valid, so rd_data is
  // never seen half-updated.
  // --------------------------------------------------------------------------
  assign rd_data = sel ? period_q : {{(WIDTH-7){1'b0}}, duty_q};
  assign valid   = valid_q;
  assign busy    = (state_q == S_DIVIDE);
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_capture                                               |
// | Description : Directed self-checking bench for pwm_capture. Drives PWM     |
// |               patterns with hand-computed period/duty expectations.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;

  localparam int WIDTH = 12;
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int LAT = 13;  // pin edge -> valid: (SYNC_STAGES+3) + 8
`else
  localparam int LAT = 11;  // pin edge -> valid: (SYNC_STAGES+1) + 8
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic             sel = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             valid;
  logic             busy;
  logic             overrun;

  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int rise_cyc = 0;
  int vec_cnt = 0;
  int err_cnt = 0;

  pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .sel     (sel),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_cycles(input logic val, input int n);
    pwm_in = val;
    tick(n);
  endtask

  // n periods of a clean PWM; rise_cyc records the last rising edge.
  task automatic train(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      rise_cyc = cyc;
      pwm_cycles(1'b1, hi);
      pwm_cycles(1'b0, per - hi);
    end
  endtask

  task automatic read_res(output int per, output int duty);
    sel = 1'b1;
    #1 per = int'(rd_data);
    sel = 1'b0;
    #1 duty = int'(rd_data);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    pwm_in = 1'b0;
    sel = 1'b0;
    ovr_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  int p, d, base, lat;

  initial begin
    // ---------------- reset state ----------------
    tick(3);
    read_res(p, d);
    check("rst_period", p, 0);
    check("rst_duty", d, 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(1);

    // ---------------- period 200, duty 30 loopback ----------------
    base = valid_cnt;
    train(200, 60, 3);
    tick(2);
    check("a_valid_cnt", valid_cnt - base, 2);
    read_res(p, d);
    check("a_period", p, 200);
    check("a_duty", d, 30);
    check("a_latency", last_valid_cyc - rise_cyc, LAT);
    check("a_overrun", int'(overrun), 0);
    check("a_busy", int'(busy), 0);

    // ---------------- per 7 hi 3: overrun ----------------
    reset_dut();
    base = valid_cnt;
    train(7, 3, 3);
    pwm_cycles(1'b0, 20);
    check("b_valid_cnt", valid_cnt - base, 1);
    read_res(p, d);
    check("b_period", p, 7);
    check("b_duty", d, 42);
    check("b_overrun", int'(overrun), 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("b_ovr_clr", int'(overrun), 0);

    // ---------------- stuck high: timeout ----------------
    reset_dut();
    base = valid_cnt;
    rise_cyc = cyc;
    pwm_in = 1'b1;
    for (int i = 0; i < 4300 && valid_cnt == base; i++) tick(1);
    check("c_timeout_seen", valid_cnt - base, 1);
    lat = last_valid_cyc - rise_cyc;
    check("c_timeout_window", int'(lat >= 4095 && lat <= 4110), 1);
    tick(30);
    check("c_single_valid", valid_cnt - base, 1);
    read_res(p, d);
    check("c_period", p, 0);
    check("c_duty", d, 100);
    check("c_busy", int'(busy), 0);

    // ---------------- per 100 hi 33 ----------------
    reset_dut();
    base = valid_cnt;
    train(100, 33, 2);
    check("d_valid_cnt", valid_cnt - base, 1);
    read_res(p, d);
    check("d_period", p, 100);
    check("d_duty", d, 33);

    // ---------------- per 3000 hi 1: truncation ----------------
    reset_dut();
    base = valid_cnt;
    train(3000, 1, 2);
    check("e_valid_cnt", valid_cnt - base, 1);
    sel = 1'b1;
    #1 check("e_rd_period", int'(rd_data), 3000);
    sel = 1'b0;
    #1 check("e_rd_duty", int'(rd_data), 0);

    // ---------------- reset during DIVIDE ----------------
    reset_dut();
    base = valid_cnt;
    train(50, 25, 1);
    pwm_in = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) tick(1);
    check("f_busy_seen", int'(busy), 1);
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(1);
    read_res(p, d);
    check("f_rst_period", p, 0);
    check("f_rst_duty", d, 0);
    check("f_rst_busy", int'(busy), 0);
    check("f_rst_valid", int'(valid), 0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check("f_no_valid", valid_cnt - base, 0);
    train(20, 10, 1);
    pwm_cycles(1'b0, 15);
    check("f_one_rise", valid_cnt - base, 0);
    pwm_cycles(1'b1, 10);
    pwm_cycles(1'b0, 12);
    check("f_two_rises", valid_cnt - base, 1);
    read_res(p, d);
    check("f_period", p, 35);
    check("f_duty", d, 28);

    // ---------------- 1-cycle low spike inside the high phase ----------------
    reset_dut();
    base = valid_cnt;
    pwm_cycles(1'b1, 10);
    pwm_cycles(1'b0, 1);
    pwm_cycles(1'b1, 9);
    pwm_cycles(1'b0, 20);
    train(40, 20, 1);
    pwm_cycles(1'b0, 5);
    read_res(p, d);
`ifdef PWM_CAPTURE_DEGLITCH_EN
    check("g_valid_cnt", valid_cnt - base, 1);
    check("g_period", p, 40);
    check("g_duty", d, 50);
`else
    check("g_valid_cnt", valid_cnt - base, 2);
    check("g_period", p, 29);
    check("g_duty", d, 31);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
